// File: rtl/product_accumulator.sv
// product_accumulator
// Accumulates a programmed-length burst of 8-bit unsigned products into a
// wide accumulator. It then presents the total and a sticky carry-out flag
// on a held output handshake.
//
// Parameters
//   ACC_W  accumulator / result width (>= 8)
//   LEN_W  burst-length field width
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, len        burst request (honoured in IDLE only) and its length
//   in_valid/in_ready input handshake; in_p is the product
//   out_valid/out_ready output handshake; out_sum/out_ovf are the result
//   busy              high while a burst is in ACC or HOLD
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [LEN_W-1:0] rem_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // One extra bit captures the carry out of the accumulator's top bit.
  logic [ACC_W:0]   sum_d;
  logic             ovf_d;
  logic             beat;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum_d = '0;
    sum_d = {1'b0, acc_q} + {1'b0, ACC_W'(in_p)};
    ovf_d = ovf_q | sum_d[ACC_W];
    beat  = in_valid & in_ready_q;
  end

  // Handshake flags are registered alongside the state, so in_ready and
  // out_valid never depend combinationally on in_valid or out_ready.
  // NOTE: sequential state uses non-blocking assignments only, avoiding
  // simulation races between flops that read each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      rem_q       <= '0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            rem_q  <= len;
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q    <= ACC;
              in_ready_q <= 1'b1;
            end else begin
              // Empty burst: present a zero result straight away.
              state_q     <= HOLD;
              out_sum_q   <= '0;
              out_ovf_q   <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        ACC: begin
          if (beat) begin
            acc_q <= sum_d[ACC_W-1:0];
            ovf_q <= ovf_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              // Last beat: publish the sum including this product.
              state_q     <= HOLD;
              out_sum_q   <= sum_d[ACC_W-1:0];
              out_ovf_q   <= ovf_d;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. Two instances share all inputs:
// u_w16 (ACC_W=16) for the ordinary sums and u_w8 (ACC_W=8) for the
// wrap/overflow behaviour. Expected values are hand-computed constants.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [7:0]  in_p;
  logic        out_ready;

  logic        in_ready16, out_valid16, out_ovf16, busy16;
  logic [15:0] out_sum16;
  logic        in_ready8, out_valid8, out_ovf8, busy8;
  logic [7:0]  out_sum8;

  int total;
  int bad;

  product_accumulator #(.ACC_W(16), .LEN_W(8)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready16), .in_p(in_p),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_sum(out_sum16), .out_ovf(out_ovf16), .busy(busy16)
  );

  product_accumulator #(.ACC_W(8), .LEN_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready8), .in_p(in_p),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .out_ovf(out_ovf8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks both instances' flags at once.
  task automatic check_flags(input string tag, input logic rdy, input logic vld, input logic bsy);
    check({tag, " in_ready16"},  {31'd0, in_ready16},  {31'd0, rdy});
    check({tag, " out_valid16"}, {31'd0, out_valid16}, {31'd0, vld});
    check({tag, " busy16"},      {31'd0, busy16},      {31'd0, bsy});
    check({tag, " in_ready8"},   {31'd0, in_ready8},   {31'd0, rdy});
    check({tag, " out_valid8"},  {31'd0, out_valid8},  {31'd0, vld});
    check({tag, " busy8"},       {31'd0, busy8},       {31'd0, bsy});
  endtask

  task automatic check_result(input string tag, input logic [15:0] s16, input logic o16,
                              input logic [7:0] s8, input logic o8);
    check({tag, " sum16"}, {16'd0, out_sum16}, {16'd0, s16});
    check({tag, " ovf16"}, {31'd0, out_ovf16}, {31'd0, o16});
    check({tag, " sum8"},  {24'd0, out_sum8},  {24'd0, s8});
    check({tag, " ovf8"},  {31'd0, out_ovf8},  {31'd0, o8});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_p      = 8'd0;
    out_ready = 1'b0;

    // ---- Reset state ----
    #3 rst_n = 1'b0;
    #3;
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check_result("reset", 16'd0, 1'b0, 8'd0, 1'b0);
    #14 rst_n = 1'b1;
    step();
    check_flags("idle after reset", 1'b0, 1'b0, 1'b0);

    // ---- Basic burst: len=4, 225 x4 ----
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    check_flags("basic acc entry", 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; in_p = 8'd225; out_ready = 1'b1;
    step(); step(); step();
    check_flags("basic after 3 beats", 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check_flags("basic hold", 1'b0, 1'b1, 1'b1);
    // 900 mod 256 = 132, with carries on the 8-bit instance.
    check_result("basic", 16'd900, 1'b0, 8'd132, 1'b1);
    step();
    out_ready = 1'b0;
    check_flags("basic back to idle", 1'b0, 1'b0, 1'b0);
    check_result("basic kept in idle", 16'd900, 1'b0, 8'd132, 1'b1);

    // ---- Zero length ----
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    check_flags("zero len hold", 1'b0, 1'b1, 1'b1);
    check_result("zero len", 16'd0, 1'b0, 8'd0, 1'b0);
    step();
    check_flags("zero len still hold", 1'b0, 1'b1, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_flags("zero len idle", 1'b0, 1'b0, 1'b0);

    // ---- Bubbles and backpressure: 10, 20, 30 ----
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_p = 8'd10;
    step();
    in_valid = 1'b0;
    step(); step();
    check_flags("bubble wait", 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; in_p = 8'd20;
    step();
    in_valid = 1'b0;
    step(); step();
    check_flags("bubble wait 2", 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; in_p = 8'd30;
    step();
    in_valid = 1'b0;
    check_flags("bubble hold", 1'b0, 1'b1, 1'b1);
    check_result("bubble", 16'd60, 1'b0, 8'd60, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check({"backpressure out_valid16"}, {31'd0, out_valid16}, 32'd1);
      check({"backpressure sum16"}, {16'd0, out_sum16}, 32'd60);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_flags("backpressure release", 1'b0, 1'b0, 1'b0);
    check_result("bubble kept in idle", 16'd60, 1'b0, 8'd60, 1'b0);

    // ---- Overflow wrap: 200 + 200, then a clean burst of 5 ----
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_p = 8'd200; out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    check_flags("ovf hold", 1'b0, 1'b1, 1'b1);
    check_result("ovf", 16'd400, 1'b0, 8'd144, 1'b1);
    step();
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_p = 8'd5;
    step();
    in_valid = 1'b0;
    check_result("post ovf clears flag", 16'd5, 1'b0, 8'd5, 1'b0);
    step();
    out_ready = 1'b0;
    check_flags("post ovf idle", 1'b0, 1'b0, 1'b0);

    // ---- Ignored start in ACC and HOLD ----
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b1; len = 8'd9;          // ignored: in ACC
    in_valid = 1'b1; in_p = 8'd1;
    step();
    start = 1'b0;
    in_p = 8'd2;
    step();
    in_valid = 1'b0;
    check_result("ignored start", 16'd3, 1'b0, 8'd3, 1'b0);
    start = 1'b1; len = 8'd9;          // ignored: in HOLD
    step();
    start = 1'b0;
    check_flags("ignored start hold", 1'b0, 1'b1, 1'b1);
    check_result("ignored start stable", 16'd3, 1'b0, 8'd3, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step(); step();
    check_flags("no queued start", 1'b0, 1'b0, 1'b0);

    // ---- Async reset mid-burst ----
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_p = 8'd50;
    step(); step();
    in_valid = 1'b0;
    check_flags("pre reset acc", 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_flags("async reset", 1'b0, 1'b0, 1'b0);
    check_result("async reset", 16'd0, 1'b0, 8'd0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    check_flags("after reset idle", 1'b0, 1'b0, 1'b0);
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_p = 8'd7;
    step();
    in_valid = 1'b0;
    check_flags("post reset hold", 1'b0, 1'b1, 1'b1);
    check_result("post reset burst", 16'd7, 1'b0, 8'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
